key_event_encoder: RTL and testbench

Input-conditioning stage directly upstream of the calculator core. It synchronizes and debounces the 16 raw calculator buttons: digits KEY[9:0], Add, Sub, Mul, Div, set and append. Each debounced press becomes a 4-bit event code, queued in a small FIFO. The core pops codes one at a time over a valid/ready handshake, so bounce, simultaneous presses and a busy core never produce duplicated or lost keystrokes silently.

---
 rtl/calc_pkg.sv | 31 +++
 rtl/key_debounce.sv | 69 ++++++
 rtl/key_event_encoder.sv | 134 +++++++++++++
 tb/tb_key_event_encoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator front end: event code type, the
// operator event codes that follow the ten digit codes, the key count, and a
// helper that picks the lowest-index set bit of a key vector.
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int NUM_KEYS = 16;

  typedef logic [3:0] ev_code_t;

  localparam ev_code_t EV_ADD    = 4'd10;
  localparam ev_code_t EV_SUB    = 4'd11;
  localparam ev_code_t EV_MUL    = 4'd12;
  localparam ev_code_t EV_DIV    = 4'd13;
  localparam ev_code_t EV_SET    = 4'd14;
  localparam ev_code_t EV_APPEND = 4'd15;

  // Index of the lowest set bit; returns 0 for an all-zero vector, so callers
  // must qualify the result with a non-zero test.
  function automatic ev_code_t lowest_set(input logic [NUM_KEYS-1:0] v);
    ev_code_t r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) r = ev_code_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One button channel: 2-FF synchronizer, agreement counter evaluated on the
// sample tick, and the debounced level.
// Ports:
//   clk      - block clock
//   rst      - synchronous active-high reset
//   raw_i    - asynchronous raw button (1 = pressed)
//   tick_i   - one-cycle sample strobe
//   level_o  - debounced level
//   press_o  - combinational strobe, high in the tick cycle whose edge turns
//              level_o from 0 to 1 (lets the caller register the press on the
//              same edge as the level change)
// -----------------------------------------------------------------------------
module key_debounce
  import calc_pkg::*;
#(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  input  logic tick_i,
  output logic level_o,
  output logic press_o
);

  logic       sync1_q, sync2_q;
  logic [3:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       flip;

  // Level flips when this tick is the STABLE_SAMPLES-th disagreeing sample.
  assign flip = tick_i && (sync2_q != level_q) &&
                (cnt_q == 4'(STABLE_SAMPLES - 1));

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick_i) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (flip) begin
        cnt_d   = '0;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  assign press_o = flip && !level_q;

endmodule

// File: rtl/key_event_encoder.sv
// -----------------------------------------------------------------------------
// key_event_encoder
// Debounces the 16 calculator buttons, turns each press into a 4-bit event
// code and queues the codes in a small FIFO drained over valid/ready.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   KEY[9:0]          - raw digit buttons
//   Add..append       - raw operator buttons (codes 10..15)
//   ev_valid/ev_code  - FIFO head
//   ev_ready          - consumer pops the head when ev_valid && ev_ready
//   key_down[15:0]    - debounced levels, bit index = event code
//   overflow          - sticky: a press was dropped (duplicate while pending)
// -----------------------------------------------------------------------------
module key_event_encoder
  import calc_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SAMPLE_HZ      = 1000,
  parameter int STABLE_SAMPLES = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          KEY,
  input  logic                Add,
  input  logic                Sub,
  input  logic                Mul,
  input  logic                Div,
  input  logic                set,
  input  logic                append,
  output logic                ev_valid,
  output ev_code_t            ev_code,
  input  logic                ev_ready,
  output logic [NUM_KEYS-1:0] key_down,
  output logic                overflow
);

  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------- sampler
  logic [DIV_W-1:0] div_q;
  logic             tick_q;

  // tick_q is high in the cycle where the divider has just wrapped to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (div_q == DIV_W'(DIV - 1));
      div_q  <= (div_q == DIV_W'(DIV - 1)) ? '0 : div_q + DIV_W'(1);
    end
  end

  // --------------------------------------------------------------- debounce
  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] press;

  assign raw = {append, set, Div, Mul, Sub, Add, KEY};

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .STABLE_SAMPLES(STABLE_SAMPLES)
      ) u_db (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (raw[gi]),
        .tick_i  (tick_q),
        .level_o (level[gi]),
        .press_o (press[gi])
      );
    end
  endgenerate

  assign key_down = level;

  // ------------------------------------------------------------------- FIFO
  ev_code_t           mem_q [FIFO_DEPTH];
  logic [PTR_W:0]     wr_q, rd_q;
  logic [PTR_W:0]     used;
  logic               full, empty;
  logic               pop, push;

  assign used  = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (used == (PTR_W+1)'(FIFO_DEPTH));
  assign pop   = !empty && ev_ready;

  // ---------------------------------------------------------------- arbiter
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [NUM_KEYS-1:0] clear_mask;
  logic                overflow_q, overflow_d;
  ev_code_t            push_code;

  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push      = (|pending_q) && (!full || pop);
  assign push_code = lowest_set(pending_q);
  assign clear_mask = push ? (NUM_KEYS'(1) << push_code) : '0;

  always_comb begin
    pending_d  = (pending_q & ~clear_mask) | press;
    // A press only counts as dropped if its earlier copy is still waiting;
    // a bit being pushed this cycle simply re-arms.
    overflow_d = overflow_q | (|(press & pending_q & ~clear_mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      if (push) wr_q <= wr_q + (PTR_W+1)'(1);
      if (pop)  rd_q <= rd_q + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: reads are masked by the pointer-derived valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[PTR_W-1:0]] <= push_code;
  end

  assign ev_valid = !empty;
  assign ev_code  = empty ? '0 : mem_q[rd_q[PTR_W-1:0]];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_encoder.sv
module tb_key_event_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] raw = '0;
  logic        ev_ready = 1'b0;
  logic        ev_valid;
  logic [3:0]  ev_code;
  logic [15:0] key_down;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_ev  = 0;
  int ev_cyc[$];
  int exp_q[$];
  int kd7_rise_cyc = -1;
  int kd10_rises   = 0;
  logic [15:0] kd_prev = '0;

  key_event_encoder #(
    .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_SAMPLES(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .KEY(raw[9:0]), .Add(raw[10]), .Sub(raw[11]), .Mul(raw[12]),
    .Div(raw[13]), .set(raw[14]), .append(raw[15]),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ready(ev_ready),
    .key_down(key_down), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard whenever a handshake completes.
  always @(negedge clk) begin
    if (rst) begin
      kd_prev = '0;
    end else begin
      if (key_down[7] && !kd_prev[7]) kd7_rise_cyc = cyc;
      if (key_down[10] && !kd_prev[10]) kd10_rises++;
      kd_prev = key_down;
      if (ev_valid && ev_ready) begin
        n_ev++;
        ev_cyc.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: got code %0d want none", ev_code);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (ev_code !== 4'(e)) begin
            bad++;
            $display("FAIL event_code: got %0d want %0d", ev_code, e);
          end else begin
            $display("event code=%0d cycle=%0d", ev_code, cyc);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int max);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max) begin
      step(1);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int base, n;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", ev_valid, 0);
    check("reset_code", ev_code, 0);
    check("reset_key_down", key_down, 0);
    check("reset_overflow", overflow, 0);

    // Clean press of KEY[7]
    step(1);
    ev_ready = 1'b1;
    base = n_ev;
    exp_q.push_back(7);
    raw[7] = 1'b1;
    step(100);
    raw[7] = 1'b0;
    step(80);
    wait_drain("clean_drain", 20);
    check("clean_count", n_ev - base, 1);
    check("clean_latency", ev_cyc[ev_cyc.size()-1] - kd7_rise_cyc, 1);
    check("clean_released", key_down[7], 0);

    // Bounce on Add
    base = n_ev;
    kd10_rises = 0;
    for (int t = 0; t < 200; t += 15) begin
      raw[10] = ~raw[10];
      step(15);
    end
    check("bounce_no_level", kd10_rises, 0);
    check("bounce_no_event", n_ev - base, 0);
    exp_q.push_back(10);
    raw[10] = 1'b1;
    step(80);
    wait_drain("bounce_drain", 20);
    check("bounce_rises", kd10_rises, 1);
    check("bounce_count", n_ev - base, 1);
    raw[10] = 1'b0;
    step(80);

    // Simultaneous KEY[3], Mul, append
    exp_q.push_back(3); exp_q.push_back(12); exp_q.push_back(15);
    raw[3] = 1'b1; raw[12] = 1'b1; raw[15] = 1'b1;
    step(80);
    wait_drain("simul_drain", 20);
    n = ev_cyc.size();
    check("simul_gap1", ev_cyc[n-2] - ev_cyc[n-3], 1);
    check("simul_gap2", ev_cyc[n-1] - ev_cyc[n-2], 1);
    raw = '0;
    step(80);

    // Backpressure: five presses into a four-deep FIFO
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(i);
    raw[4:0] = 5'b11111;
    step(80);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_stall_valid", ev_valid, 1);
      check("bp_stall_code", ev_code, 0);
    end
    step(1);
    raw = '0;
    ev_ready = 1'b1;
    wait_drain("bp_drain", 20);
    check("bp_overflow", overflow, 0);
    step(80);

    // Overflow: duplicate KEY[5] press while its first press waits
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    exp_q.push_back(5);
    raw[3:0] = 4'b1111;
    step(80);
    raw[3:0] = 4'b0000;
    step(80);
    raw[5] = 1'b1;
    step(80);
    check("ovf_before_dup", overflow, 0);
    raw[5] = 1'b0;
    step(80);
    raw[5] = 1'b1;
    step(80);
    check("ovf_set", overflow, 1);
    ev_ready = 1'b1;
    wait_drain("ovf_drain", 20);
    raw[5] = 1'b0;
    step(80);
    check("ovf_sticky", overflow, 1);

    // Reset mid-stream with three queued events
    ev_ready = 1'b0;
    raw[2:0] = 3'b111;
    step(80);
    @(negedge clk);
    check("rst_pre_valid", ev_valid, 1);
    step(1);
    rst = 1'b1;
    raw = '0;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", ev_valid, 0);
    check("rst_key_down", key_down, 0);
    check("rst_overflow", overflow, 0);
    base = n_ev;
    ev_ready = 1'b1;
    step(80);
    check("rst_no_events", n_ev - base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
